// File: rtl/serial_sub_inverse_if.sv
// Operand/result handshake bundle for serial_sub_inverse.
// COUT exists only when SERIAL_SUB_INVERSE_COUT_EN is defined.
interface serial_sub_inverse_if #(
    parameter int unsigned WIDTH = 2
);
    logic             I_VALID;
    logic             I_READY;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] B;
    logic             O_VALID;
    logic             O_READY;
    logic [WIDTH-1:0] O;
`ifdef SERIAL_SUB_INVERSE_COUT_EN
    logic             COUT;
`endif

    modport master (
        output I_VALID, D, B, O_READY,
`ifdef SERIAL_SUB_INVERSE_COUT_EN
        input  COUT,
`endif
        input  I_READY, O_VALID, O
    );

    modport slave (
        input  I_VALID, D, B, O_READY,
`ifdef SERIAL_SUB_INVERSE_COUT_EN
        output COUT,
`endif
        output I_READY, O_VALID, O
    );
endinterface

// File: rtl/serial_sub_inverse.sv
// Bit-serial reconstructing adder: O = (D + B) mod 2^WIDTH, one bit per clock.
// Optional final carry output enabled by SERIAL_SUB_INVERSE_COUT_EN.
module serial_sub_inverse #(
    parameter int unsigned WIDTH = 2
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    serial_sub_inverse_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             i_ready_q, i_ready_d;
    logic             o_valid_q, o_valid_d;
    logic             sum_c;
    logic             carry_c;
`ifdef SERIAL_SUB_INVERSE_COUT_EN
    logic             cout_q, cout_d;
`endif

    // Single full-adder slice on the current LSBs
    always_comb begin
        sum_c   = d_q[0] ^ b_q[0] ^ c_q;
        carry_c = (d_q[0] & b_q[0]) | (c_q & (d_q[0] ^ b_q[0]));
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        b_d     = b_q;
        res_d   = res_q;
        o_d     = o_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_INVERSE_COUT_EN
        cout_d  = cout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.I_VALID) begin
                    d_d     = bus.D;
                    b_d     = bus.B;
                    res_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                d_d   = d_q >> 1;
                b_d   = b_q >> 1;
                // Sum bits enter at the MSB so the last one lands LSB-aligned
                res_d = (res_q >> 1) | (WIDTH'(sum_c) << (WIDTH - 1));
                c_d   = carry_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    o_d     = res_d;
`ifdef SERIAL_SUB_INVERSE_COUT_EN
                    cout_d  = carry_c;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.O_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        i_ready_d = (state_d == ST_IDLE);
        o_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            d_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            o_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
`ifdef SERIAL_SUB_INVERSE_COUT_EN
            cout_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            b_q       <= b_d;
            res_q     <= res_d;
            o_q       <= o_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            i_ready_q <= i_ready_d;
            o_valid_q <= o_valid_d;
`ifdef SERIAL_SUB_INVERSE_COUT_EN
            cout_q    <= cout_d;
`endif
        end
    end

    assign bus.I_READY = i_ready_q;
    assign bus.O_VALID = o_valid_q;
    assign bus.O       = o_q;
`ifdef SERIAL_SUB_INVERSE_COUT_EN
    assign bus.COUT    = cout_q;
`endif

endmodule

// File: tb/tb_serial_sub_inverse.sv
// Self-checking bench for serial_sub_inverse at WIDTH=2 and WIDTH=8, scoreboard-based.
module tb_serial_sub_inverse;
    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    serial_sub_inverse_if #(.WIDTH(2)) a_if ();
    serial_sub_inverse_if #(.WIDTH(8)) w_if ();

    serial_sub_inverse #(.WIDTH(2)) u_dut2 (.CLK(CLK), .RESETN(RESETN), .bus(a_if));
    serial_sub_inverse #(.WIDTH(8)) u_dut8 (.CLK(CLK), .RESETN(RESETN), .bus(w_if));

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];  // {carry, sum zero-extended to 8 bits}

    function automatic logic [7:0] get_o(input bit wide);
        return wide ? w_if.O : {6'b0, a_if.O};
    endfunction
    function automatic logic get_ov(input bit wide);
        return wide ? w_if.O_VALID : a_if.O_VALID;
    endfunction
    function automatic logic get_ir(input bit wide);
        return wide ? w_if.I_READY : a_if.I_READY;
    endfunction
`ifdef SERIAL_SUB_INVERSE_COUT_EN
    function automatic logic get_cout(input bit wide);
        return wide ? w_if.COUT : a_if.COUT;
    endfunction
`endif

    task automatic set_in(input bit wide, input logic v, input logic [7:0] d, input logic [7:0] b);
        if (wide) begin
            w_if.I_VALID = v; w_if.D = d; w_if.B = b;
        end else begin
            a_if.I_VALID = v; a_if.D = d[1:0]; a_if.B = b[1:0];
        end
    endtask

    task automatic set_ordy(input logic v);
        a_if.O_READY = v;
        w_if.O_READY = v;
    endtask

    // Wait for I_READY, present one operand pair, record the expected result
    task automatic send(input bit wide, input logic [7:0] d, input logic [7:0] b);
        int n = 0;
        logic [2:0] s2;
        @(negedge CLK);
        while (!get_ir(wide) && n < 64) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (get_ir(wide) !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: I_READY got %b required 1", get_ir(wide));
        end
        set_in(wide, 1'b1, d, b);
        if (wide) begin
            sb.push_back({1'b0, d} + {1'b0, b});
        end else begin
            s2 = {1'b0, d[1:0]} + {1'b0, b[1:0]};
            sb.push_back({s2[2], 6'b0, s2[1:0]});
        end
        @(negedge CLK);
        set_in(wide, 1'b0, 8'h00, 8'h00);
    endtask

    // Called at the negedge right after the accept edge; checks latency and result
    task automatic recv(input bit wide, output logic [7:0] got);
        int n = 0;
        int lat = wide ? 8 : 2;
        logic [8:0] exp;
        got = 8'h00;
        while (!get_ov(wide) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL latency: cycles got %0d required %0d", n, lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: entries got 0 required 1");
            return;
        end
        exp = sb.pop_front();
        got = get_o(wide);
        if (got !== exp[7:0]) begin
            errors++;
            $display("FAIL result: O got %0h required %0h", got, exp[7:0]);
        end
`ifdef SERIAL_SUB_INVERSE_COUT_EN
        checks++;
        if (get_cout(wide) !== exp[8]) begin
            errors++;
            $display("FAIL cout: COUT got %b required %b", get_cout(wide), exp[8]);
        end
`endif
        if (a_if.O_READY) begin
            @(negedge CLK);
            checks++;
            if (get_ov(wide) !== 1'b0 || get_ir(wide) !== 1'b1) begin
                errors++;
                $display("FAIL done_one_cycle: O_VALID/I_READY got %b/%b required 0/1",
                         get_ov(wide), get_ir(wide));
            end
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 8'h00);
        set_in(1'b1, 1'b0, 8'h00, 8'h00);
        set_ordy(1'b1);
        #12;
        checks++;
        if (a_if.I_READY !== 1'b1 || a_if.O_VALID !== 1'b0 || a_if.O !== 2'b00) begin
            errors++;
            $display("FAIL reset_w2: rdy/vld/O got %b/%b/%0h required 1/0/0",
                     a_if.I_READY, a_if.O_VALID, a_if.O);
        end
        checks++;
        if (w_if.I_READY !== 1'b1 || w_if.O_VALID !== 1'b0 || w_if.O !== 8'h00) begin
            errors++;
            $display("FAIL reset_w8: rdy/vld/O got %b/%b/%0h required 1/0/0",
                     w_if.I_READY, w_if.O_VALID, w_if.O);
        end
`ifdef SERIAL_SUB_INVERSE_COUT_EN
        checks++;
        if (a_if.COUT !== 1'b0 || w_if.COUT !== 1'b0) begin
            errors++;
            $display("FAIL reset_cout: COUT got %b/%b required 0/0", a_if.COUT, w_if.COUT);
        end
`endif
        @(negedge CLK);
        RESETN = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] got;
        send(1'b0, 8'h2, 8'h1);
        recv(1'b0, got);
        send(1'b0, 8'h1, 8'h3);
        recv(1'b0, got);
    endtask

    task automatic test_backpressure();
        logic [7:0] got;
        logic bad = 1'b0;
        set_ordy(1'b0);
        send(1'b0, 8'h1, 8'h2);
        recv(1'b0, got);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, (i == 1 || i == 3), 8'h3, 8'h3);
            @(negedge CLK);
            checks++;
            if (a_if.O !== 2'b11 || a_if.O_VALID !== 1'b1 || a_if.I_READY !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: O/vld/rdy got %0h/%b/%b required 3/1/0",
                         a_if.O, a_if.O_VALID, a_if.I_READY);
            end
        end
        set_in(1'b0, 1'b0, 8'h0, 8'h0);
        set_ordy(1'b1);
        @(negedge CLK);
        checks++;
        if (a_if.I_READY !== 1'b1 || a_if.O_VALID !== 1'b0 || a_if.O !== 2'b11) begin
            errors++;
            $display("FAIL backpressure_release: rdy/vld/O got %b/%b/%0h required 1/0/3",
                     a_if.I_READY, a_if.O_VALID, a_if.O);
        end
        repeat (6) begin
            @(negedge CLK);
            if (a_if.O_VALID !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL ignored_operands: spurious O_VALID got 1 required 0");
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        logic [8:0] dropped;
        send(1'b0, 8'h1, 8'h2);
        @(negedge CLK);
        RESETN = 1'b0;
        #1;
        checks++;
        if (a_if.O_VALID !== 1'b0 || a_if.O !== 2'b00 || a_if.I_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: vld/O/rdy got %b/%0h/%b required 0/0/1",
                     a_if.O_VALID, a_if.O, a_if.I_READY);
        end
        dropped = sb.pop_back();
        @(negedge CLK);
        RESETN = 1'b1;
        send(1'b0, 8'h1, 8'h1);
        recv(1'b0, got);
    endtask

    task automatic test_roundtrip();
        logic [7:0] got;
        logic [1:0] av, bv, dv;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                av = 2'(a);
                bv = 2'(b);
                dv = av - bv;
                send(1'b0, {6'b0, dv}, {6'b0, bv});
                recv(1'b0, got);
                checks++;
                if (got[1:0] !== av) begin
                    errors++;
                    $display("FAIL roundtrip: O got %0h required A=%0h (B=%0h)", got[1:0], av, bv);
                end
            end
        end
    endtask

    task automatic test_wide();
        logic [7:0] got;
        logic [7:0] rd, rb;
        send(1'b1, 8'hFF, 8'h01);
        recv(1'b1, got);
        send(1'b1, 8'h00, 8'h00);
        recv(1'b1, got);
        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom);
            rb = 8'($urandom);
            send(1'b1, rd, rb);
            recv(1'b1, got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_roundtrip();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub_inverse.md
Name: serial_sub_inverse

Overview:
- Bit-serial reconstructing adder; the inverse of the 2-bit subtractor datapath.
- Given a difference D and the subtrahend B, it recovers the minuend A = D + B mod 2^WIDTH.
- Uses one full-adder slice (XOR sum plus majority carry, mapping to one LUT4 and one SB_CARRY on ice40) and a registered carry, one bit per clock.
- Sits downstream of the subtractor as a check/restore stage, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 2, operand and result width in bits; legal range 1..32.

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to CLK.
- I_VALID  input  1  upstream operand pair valid.
- I_READY  output  1  block can accept operands; high only in IDLE.
- D  input  WIDTH  difference operand; sampled only on accept.
- B  input  WIDTH  subtrahend operand; sampled only on accept.
- O_VALID  output  1  result valid; high only in DONE.
- O_READY  input  1  downstream accepts result.
- O  output  WIDTH  reconstructed minuend, (D + B) mod 2^WIDTH.

Behaviour:
- Reset: state=IDLE, I_READY=1, O_VALID=0, O=0, carry=0, bit counter=0, shift registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - I_READY=1.
  - Accept on a CLK edge with I_VALID&I_READY: load D and B into shift registers, clear carry and counter, go to SHIFT.
- SHIFT:
  - I_READY=0, O_VALID=0.
  - Each edge computes s = d[0]^b[0]^c and c' = (d[0]&b[0]) | (c&(d[0]^b[0])).
  - Shift D and B right by one; shift s into the result register at the MSB, shifting right.
  - Increment counter.
  - After the edge where counter reaches WIDTH, go to DONE. The result register then holds the LSB-aligned sum.
- DONE:
  - O_VALID=1; O is driven from the result register and held stable.
  - On an edge with O_READY=1, go to IDLE; O keeps its value until the next result completes.
- Latency: accept at edge t; O_VALID is high after edge t+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles; no overlap of operations.
- I_VALID asserted while not in IDLE: ignored, operands not sampled, no queuing.
- O_READY asserted outside DONE: ignored.
- O_READY held high continuously: DONE lasts exactly one cycle.
- Overflow: the carry out of the MSB is discarded; the result wraps mod 2^WIDTH.
- Reset mid-operation (any state): abort immediately, return to reset values; no partial result is ever presented.
- Counter width is $clog2(WIDTH+1); it must not wrap before WIDTH.

Optional Feature:
- Macro: SERIAL_SUB_INVERSE_COUT_EN.
- Defined:
  - Extra port COUT, output, 1 bit: the final carry out of the MSB.
  - Registered at the transition into DONE; valid with O_VALID and held until the next result.
  - Reset value 0.
- Undefined:
  - No COUT port; the final carry is discarded.
  - All other behaviour is identical.

Test Plan:
- WIDTH=2, D=2'b10, B=2'b01, O_READY=1 -> O_VALID high exactly 2 cycles after accept; O=2'b11; COUT=0 if enabled; O_VALID high for 1 cycle.
- WIDTH=2, D=2'b01, B=2'b11 -> O=2'b00 (wrap); COUT=1 if enabled.
- Backpressure: result pending with O_READY=0 for 5 cycles, I_VALID pulsed with D=3, B=3 -> O stable, I_READY=0 throughout; second operand pair never processed; after O_READY=1, I_READY=1 next cycle.
- Reset mid-SHIFT: RESETN low one cycle after accept -> O_VALID=0, O=0, I_READY=1 during reset; after release, the next op D=1, B=1 gives O=2'b10.
- Exhaustive round-trip, WIDTH=2: all 16 (A,B) pairs, D=(A-B) mod 4 computed by the 2-bit subtractor and fed in -> O==A for every pair.
- WIDTH=8 corner: D=8'hFF, B=8'h01 -> O=8'h00 after 8 cycles, COUT=1; D=8'h00, B=8'h00 -> O=8'h00, COUT=0.
